// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: decodes loads/stores, aligns store data onto a
// valid/ready memory bus and extracts/extends load data from the response word.
module lsu_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0]      in_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_rdata,
  output logic                       out_err,
  output logic                       bus_req_valid,
  input  logic                       bus_req_ready,
  output logic                       bus_req_we,
  output logic [ADDR_WIDTH-1:0]      bus_req_addr,
  output logic [DATA_WIDTH-1:0]      bus_req_wdata,
  output logic [DATA_WIDTH/8-1:0]    bus_req_strb,
  input  logic                       bus_rsp_valid,
  output logic                       bus_rsp_ready,
  input  logic [DATA_WIDTH-1:0]      bus_rsp_data,
  input  logic                       bus_rsp_err
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 2);
  localparam bit TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Shift the addressed lane down, then sign- or zero-extend per funct3.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [OFF_W-1:0]      off,
    input logic [2:0]            f3
  );
    logic [DATA_WIDTH-1:0] w;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    w = word >> {off, 3'b000};
    b = w[7:0];
    h = w[15:0];
    case (f3)
      3'b000:  return DATA_WIDTH'(b);
      3'b001:  return DATA_WIDTH'(h);
      3'b100:  return DATA_WIDTH'(w[7:0]);
      3'b101:  return DATA_WIDTH'(w[15:0]);
      default: return DATA_WIDTH'(w[31:0]);
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_align(
    input logic [DATA_WIDTH-1:0] data,
    input logic [OFF_W-1:0]      off,
    input logic [1:0]            size
  );
    logic [DATA_WIDTH-1:0] m;
    case (size)
      2'd0:    m = DATA_WIDTH'(data[7:0]);
      2'd1:    m = DATA_WIDTH'(data[15:0]);
      default: m = DATA_WIDTH'(data[31:0]);
    endcase
    return m << {off, 3'b000};
  endfunction

  function automatic logic [STRB_W-1:0] store_strb(
    input logic [OFF_W-1:0] off,
    input logic [1:0]       size
  );
    logic [STRB_W-1:0] base;
    case (size)
      2'd0:    base = STRB_W'(4'h1);
      2'd1:    base = STRB_W'(4'h3);
      default: base = STRB_W'(4'hF);
    endcase
    return base << off;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [DATA_WIDTH-1:0]  req_wdata_q;
  logic [STRB_W-1:0]      req_strb_q;
  logic                   req_we_q;
  logic [2:0]             f3_q;
  logic [OFF_W-1:0]       off_q;

  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [OFF_W-1:0] off;
  logic             is_load, is_store, legal, misal, accept;
  logic             unused_inst;

  assign opc         = in_inst[6:0];
  assign f3          = in_inst[14:12];
  assign off         = in_addr[OFF_W-1:0];
  assign accept      = (state_q == S_IDLE) && in_valid;
  assign unused_inst = ^{in_inst[31:15], in_inst[11:7]};

  always_comb begin
    is_load  = (opc == OPC_LOAD);
    is_store = (opc == OPC_STORE);
    legal    = 1'b0;
    if (is_load) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (f3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
    misal = ((f3[1:0] == 2'd1) && off[0]) ||
            ((f3[1:0] == 2'd2) && (off[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          if (!legal || misal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle wins over the timeout.
        if (bus_rsp_valid) begin
          state_d = S_DONE;
          err_d   = bus_rsp_err;
          rdata_d = (bus_rsp_err || req_we_q) ? '0 : load_extend(bus_rsp_data, off_q, f3_q);
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers carry no reset; outputs are qualified by state instead.
  always_ff @(posedge clk) begin
    err_q   <= err_d;
    rdata_q <= rdata_d;
    if (accept) begin
      req_addr_q  <= {in_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      req_wdata_q <= store_align(in_wdata, off, f3[1:0]);
      req_strb_q  <= is_store ? store_strb(off, f3[1:0]) : '0;
      req_we_q    <= is_store;
      f3_q        <= f3;
      off_q       <= off;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign bus_req_valid = (state_q == S_REQ);
  assign bus_rsp_ready = (state_q == S_WAIT);
  assign out_valid     = (state_q == S_DONE);
  assign out_err       = out_valid & err_q;
  assign out_rdata     = out_valid ? rdata_q : '0;
  assign bus_req_we    = req_we_q;
  assign bus_req_addr  = req_addr_q;
  assign bus_req_wdata = req_wdata_q;
  assign bus_req_strb  = req_strb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed corner cases plus randomized ops checked against
// an arithmetic reference model of the load/store rules.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  localparam int TO = 4;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_strb;
  logic        bus_rsp_valid, bus_rsp_ready, bus_rsp_err;
  logic [31:0] bus_rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready),
    .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err)
  );

  typedef struct {
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic        saw_req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        req_stable;
    logic        out_stable;
    logic        timed_out;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } obs_t;

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    return {17'h0, f3, 5'd0, opc};
  endfunction

  // Reference: what the op should do, from access size and byte offset arithmetic.
  function automatic exp_t model(input logic [31:0] inst, addr, wdata, rsp_data,
                                 input logic rsp_err, input int req_stall, rsp_delay);
    exp_t   e;
    int     size, off;
    bit     sgn, ok, st;
    longint v, mask;
    e.bus = 0; e.we = 0; e.addr = 0; e.wdata = 0; e.strb = 0; e.err = 0; e.rdata = 0; e.lat = 1;
    off = int'(addr % 4);
    ok = 1; st = 0; sgn = 0; size = 4;
    if (inst[6:0] == OPC_LD) begin
      case (inst[14:12])
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: ok = 0;
      endcase
    end else if (inst[6:0] == OPC_ST) begin
      st = 1;
      case (inst[14:12])
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: ok = 0;
      endcase
    end else begin
      ok = 0;
    end
    if (ok && (off % size) != 0) ok = 0;
    if (!ok) begin
      e.err = 1;
      return e;
    end
    e.bus  = 1;
    e.we   = st;
    e.addr = addr - 32'(off);
    e.lat  = (rsp_delay < TO) ? 3 + req_stall + rsp_delay : 2 + req_stall + TO;
    mask   = (longint'(1) << (8 * size)) - 1;
    if (st) begin
      e.strb  = 4'(((1 << size) - 1) << off);
      e.wdata = 32'((longint'(wdata) & mask) << (8 * off));
    end
    if (rsp_delay >= TO || rsp_err) begin
      e.err = 1;
    end else if (!st) begin
      v = (longint'(rsp_data) >> (8 * off)) & mask;
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  // Drives one op through the DUT acting as both bus and writeback stage.
  task automatic run_op(input logic [31:0] inst, addr, wdata, rsp_data, input logic rsp_err,
                        input int req_stall, rsp_delay, out_stall, output obs_t o);
    int req_cyc, wait_cyc;
    o.saw_req = 0; o.we = 0; o.addr = 0; o.wdata = 0; o.strb = 0;
    o.req_stable = 1; o.out_stable = 1; o.timed_out = 0; o.err = 0; o.rdata = 0; o.lat = 0;
    in_valid = 1; in_inst = inst; in_addr = addr; in_wdata = wdata;
    @(negedge clk);
    in_valid = 0;
    o.lat = 1; req_cyc = 0; wait_cyc = 0;
    while (!out_valid) begin
      if (o.lat > 200) begin
        o.timed_out = 1;
        break;
      end
      bus_req_ready = 0;
      bus_rsp_valid = 0;
      if (bus_req_valid) begin
        if (!o.saw_req) begin
          o.saw_req = 1; o.we = bus_req_we; o.addr = bus_req_addr;
          o.wdata = bus_req_wdata; o.strb = bus_req_strb;
        end else if ({bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb} !==
                     {o.we, o.addr, o.wdata, o.strb}) begin
          o.req_stable = 0;
        end
        bus_req_ready = (req_cyc >= req_stall);
        req_cyc++;
      end
      if (bus_rsp_ready) begin
        bus_rsp_valid = (wait_cyc >= rsp_delay);
        bus_rsp_data  = rsp_data;
        bus_rsp_err   = rsp_err;
        wait_cyc++;
      end
      @(negedge clk);
      o.lat++;
    end
    bus_req_ready = 0;
    bus_rsp_valid = 0;
    if (o.timed_out) return;
    o.rdata = out_rdata;
    o.err   = out_err;
    for (int k = 0; k < out_stall; k++) begin
      out_ready = 0;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_rdata !== o.rdata || out_err !== o.err) o.out_stable = 0;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b, expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset out_err: got %b, expected 0", out_err); end
    n_tests++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset bus_req_valid: got %b, expected 0", bus_req_valid); end
    n_tests++; if (bus_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset bus_rsp_ready: got %b, expected 0", bus_rsp_ready); end
    n_tests++; if (out_rdata !== 32'h0) begin n_fail++; $display("FAIL reset out_rdata: got %h, expected 0", out_rdata); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    obs_t o;
    run_op(mk_inst(OPC_LD, 3'b010), 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, o);
    n_tests++; if (o.addr !== 32'h8000_0004 || o.we !== 1'b0) begin n_fail++; $display("FAIL lw req: got addr %h we %b, expected 80000004 we 0", o.addr, o.we); end
    n_tests++; if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin n_fail++; $display("FAIL lw data: got %h err %b, expected deadbeef err 0", o.rdata, o.err); end
    n_tests++; if (o.lat !== 3) begin n_fail++; $display("FAIL lw latency: got %0d, expected 3", o.lat); end

    run_op(mk_inst(OPC_LD, 3'b000), 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb sext: got %h, expected ffffff80", o.rdata); end
    run_op(mk_inst(OPC_LD, 3'b100), 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu zext: got %h, expected 00000080", o.rdata); end

    run_op(mk_inst(OPC_ST, 3'b001), 32'h8000_0002, 32'h0000_1234, 32'h0, 0, 0, 0, 0, o);
    n_tests++; if (o.wdata !== 32'h1234_0000 || o.strb !== 4'b1100 || o.we !== 1'b1) begin n_fail++; $display("FAIL sh req: got wdata %h strb %b we %b, expected 12340000 1100 1", o.wdata, o.strb, o.we); end
    n_tests++; if (o.addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sh addr: got %h, expected 80000000", o.addr); end
    n_tests++; if (o.err !== 1'b0 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL sh result: got err %b rdata %h, expected 0 0", o.err, o.rdata); end

    run_op(mk_inst(OPC_LD, 3'b010), 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 0, o);
    n_tests++; if (o.saw_req !== 1'b0) begin n_fail++; $display("FAIL misaligned lw bus access: got %b, expected 0", o.saw_req); end
    n_tests++; if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL misaligned lw: got lat %0d err %b rdata %h, expected 1 1 0", o.lat, o.err, o.rdata); end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [31:0] insts [3];
    insts[0] = mk_inst(7'b0110011, 3'b000);
    insts[1] = mk_inst(OPC_LD, 3'b011);
    insts[2] = mk_inst(OPC_ST, 3'b100);
    for (int i = 0; i < 3; i++) begin
      run_op(insts[i], 32'h0000_1000, 32'hFFFF_FFFF, 32'h1111_1111, 0, 0, 0, 0, o);
      n_tests++; if (o.saw_req !== 1'b0 || o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL illegal[%0d]: got req %b lat %0d err %b rdata %h, expected 0 1 1 0", i, o.saw_req, o.lat, o.err, o.rdata); end
    end
  endtask

  task automatic test_stall();
    obs_t o;
    run_op(mk_inst(OPC_ST, 3'b000), 32'h8000_0009, 32'hABCD_EF5A, 32'h0, 0, 5, 2, 3, o);
    n_tests++; if (o.req_stable !== 1'b1) begin n_fail++; $display("FAIL stall req stable: got %b, expected 1", o.req_stable); end
    n_tests++; if (o.out_stable !== 1'b1) begin n_fail++; $display("FAIL stall out stable: got %b, expected 1", o.out_stable); end
    n_tests++; if (o.lat !== 10) begin n_fail++; $display("FAIL stall latency: got %0d, expected 10", o.lat); end
    n_tests++; if (o.wdata !== 32'h0000_5A00 || o.strb !== 4'b0010) begin n_fail++; $display("FAIL stall sb: got wdata %h strb %b, expected 00005a00 0010", o.wdata, o.strb); end
    run_op(mk_inst(OPC_LD, 3'b001), 32'h8000_0002, 32'h0, 32'h9876_0000, 0, 2, 1, 3, o);
    n_tests++; if (o.rdata !== 32'hFFFF_9876 || o.out_stable !== 1'b1) begin n_fail++; $display("FAIL stall lh: got %h stable %b, expected ffff9876 1", o.rdata, o.out_stable); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(mk_inst(OPC_LD, 3'b010), 32'h8000_0010, 32'h0, 32'h5555_AAAA, 0, 0, 1000, 0, o);
    n_tests++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL timeout result: got err %b rdata %h, expected 1 0", o.err, o.rdata); end
    n_tests++; if (o.lat !== 2 + TO) begin n_fail++; $display("FAIL timeout latency: got %0d, expected %0d", o.lat, 2 + TO); end
    run_op(mk_inst(OPC_LD, 3'b010), 32'h8000_0010, 32'h0, 32'h5555_AAAA, 0, 0, TO - 1, 0, o);
    n_tests++; if (o.err !== 1'b0 || o.rdata !== 32'h5555_AAAA || o.lat !== 2 + TO) begin n_fail++; $display("FAIL last-cycle rsp: got err %b rdata %h lat %0d, expected 0 5555aaaa %0d", o.err, o.rdata, o.lat, 2 + TO); end
  endtask

  task automatic test_bus_err();
    obs_t o;
    run_op(mk_inst(OPC_LD, 3'b010), 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1, 1, 1, 0, o);
    n_tests++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL bus err load: got err %b rdata %h, expected 1 0", o.err, o.rdata); end
    run_op(mk_inst(OPC_ST, 3'b010), 32'h8000_0020, 32'h1234_5678, 32'h0, 1, 0, 0, 0, o);
    n_tests++; if (o.err !== 1'b1 || o.strb !== 4'hF) begin n_fail++; $display("FAIL bus err store: got err %b strb %b, expected 1 1111", o.err, o.strb); end
  endtask

  task automatic test_reset_mid();
    int guard;
    in_valid = 1; in_inst = mk_inst(OPC_LD, 3'b010); in_addr = 32'h8000_0010; in_wdata = 0;
    @(negedge clk);
    in_valid = 0;
    guard = 0;
    while (!bus_rsp_ready && guard < 20) begin
      bus_req_ready = bus_req_valid;
      @(negedge clk);
      guard++;
    end
    bus_req_ready = 0;
    n_tests++; if (bus_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset-mid reach wait: got rsp_ready %b, expected 1", bus_rsp_ready); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus_rsp_valid = 1; bus_rsp_data = 32'h1234_5678; bus_rsp_err = 0;
    @(negedge clk);
    bus_rsp_valid = 0;
    n_tests++; if (in_ready !== 1'b1 || bus_rsp_ready !== 1'b0 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset-mid idle: got in_ready %b rsp_ready %b req_valid %b, expected 1 0 0", in_ready, bus_rsp_ready, bus_req_valid); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset-mid late rsp: got out_valid %b, expected 0", out_valid); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset-mid settle: got out_valid %b in_ready %b, expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back(input int n);
    obs_t o;
    exp_t e;
    logic [31:0] inst, addr, wdata, rd;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        re;
    int          k, rs, rdl, os;
    logic [2:0]  ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5) begin
        opc = OPC_LD;
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : ld_f3[$urandom_range(0, 4)];
      end else if (k < 9) begin
        opc = OPC_ST;
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      end else begin
        opc = 7'($urandom_range(0, 127));
        f3 = 3'($urandom_range(0, 7));
      end
      inst = $urandom;
      inst[6:0] = opc;
      inst[14:12] = f3;
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wdata = $urandom;
      rd = $urandom;
      re = ($urandom_range(0, 7) == 0);
      rs = $urandom_range(0, 3);
      rdl = $urandom_range(0, 5);
      os = $urandom_range(0, 2);
      e = model(inst, addr, wdata, rd, re, rs, rdl);
      run_op(inst, addr, wdata, rd, re, rs, rdl, os, o);
      n_tests++; if (o.timed_out || o.lat !== e.lat) begin n_fail++; $display("FAIL rand[%0d] latency: got %0d (stuck %b), expected %0d", i, o.lat, o.timed_out, e.lat); end
      n_tests++; if (o.saw_req !== e.bus) begin n_fail++; $display("FAIL rand[%0d] bus access: got %b, expected %b", i, o.saw_req, e.bus); end
      n_tests++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_fail++; $display("FAIL rand[%0d] result inst %h addr %h: got err %b rdata %h, expected err %b rdata %h", i, inst, addr, o.err, o.rdata, e.err, e.rdata); end
      if (e.bus) begin
        n_tests++; if ({o.we, o.addr, o.strb} !== {e.we, e.addr, e.strb}) begin n_fail++; $display("FAIL rand[%0d] req: got we %b addr %h strb %b, expected we %b addr %h strb %b", i, o.we, o.addr, o.strb, e.we, e.addr, e.strb); end
        if (e.we) begin
          n_tests++; if (o.wdata !== e.wdata) begin n_fail++; $display("FAIL rand[%0d] wdata: got %h, expected %h", i, o.wdata, e.wdata); end
        end
      end
      n_tests++; if (o.req_stable !== 1'b1 || o.out_stable !== 1'b1) begin n_fail++; $display("FAIL rand[%0d] stability: got req %b out %b, expected 1 1", i, o.req_stable, o.out_stable); end
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rand[%0d] return to idle: got in_ready %b out_valid %b, expected 1 0", i, in_ready, out_valid); end
      if (o.timed_out) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_inst = 0; in_addr = 0; in_wdata = 0; out_ready = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = 0; bus_rsp_err = 0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
    test_stall();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    test_back_to_back(150);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
